// File: rtl/sobel_pkg.sv
// Shared types, kernel weights and saturation helper for the Sobel edge stream.
package sobel_pkg;

   typedef logic [7:0]         pixel_t;
   typedef logic signed [10:0] grad_t;

   // Weights indexed [row][col], row 0 = top of the window.
   localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
   localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

   function automatic pixel_t sat8(input logic [10:0] v);
      return (v > 11'd255) ? 8'hFF : v[7:0];
   endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel: |Gx|+|Gy| saturated to 8 bits, optionally binarised.
module sobel_kernel
   import sobel_pkg::*;
#(
   parameter bit THRESH_EN = 1'b0,
   parameter int THRESH    = 128
) (
   input  pixel_t [8:0] win,   // element r*3+c
   output pixel_t       mag
);

   grad_t       gx;
   grad_t       gy;
   logic [10:0] abs_x;
   logic [10:0] abs_y;
   logic [10:0] abs_sum;
   pixel_t      sat;

   always_comb begin
      int acc_x;
      int acc_y;
      acc_x = 0;
      acc_y = 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            acc_x += KX[r][c] * int'(win[r*3+c]);
            acc_y += KY[r][c] * int'(win[r*3+c]);
         end
      end
      gx = grad_t'(acc_x);
      gy = grad_t'(acc_y);
   end

   assign abs_x   = gx[10] ? $unsigned(-gx) : $unsigned(gx);
   assign abs_y   = gy[10] ? $unsigned(-gy) : $unsigned(gy);
   assign abs_sum = abs_x + abs_y;   // at most 2040, never overflows 11 bits
   assign sat     = sat8(abs_sum);

   generate
      if (THRESH_EN) begin : g_thresh
         localparam pixel_t THR = pixel_t'(THRESH);
         assign mag = (sat >= THR) ? 8'hFF : 8'h00;
      end else begin : g_plain
         assign mag = sat;
      end
   endgenerate

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming raster-order 3x3 Sobel edge detector with two line buffers and
// valid/ready handshake; emits interior pixels only with frame/line markers.
module sobel_edge_stream
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter bit THRESH_EN  = 1'b0,
   parameter int THRESH     = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_pixel,
   input  logic       in_sof,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_pixel,
   output logic       out_sof,
   output logic       out_eol,
   output logic       out_eof
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0] col_reg, col_cur, col_next;
   logic [RW-1:0] row_reg, row_cur, row_next;

   pixel_t lb0 [IMG_WIDTH];   // previous line
   pixel_t lb1 [IMG_WIDTH];   // line before that

   pixel_t [8:0] win_reg;
   pixel_t [8:0] win_next;
   pixel_t       col_in [3];
   pixel_t       mag;

   logic accept;
   logic emit;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A start-of-frame beat is (0,0) no matter where the counters were.
   assign col_cur = in_sof ? '0 : col_reg;
   assign row_cur = in_sof ? '0 : row_reg;

   always_comb begin
      col_next = col_cur + COL_ONE;
      row_next = row_cur;
      if (col_cur == COL_LAST) begin
         col_next = '0;
         row_next = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (accept) begin
         col_reg <= col_next;
         row_reg <= row_next;
      end
   end

   // Line buffers are never cleared; stale data only reaches rows that never emit.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[col_cur] <= lb0[col_cur];
         lb0[col_cur] <= in_pixel;
      end
   end

   assign col_in[0] = lb1[col_cur];
   assign col_in[1] = lb0[col_cur];
   assign col_in[2] = in_pixel;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
         assign win_next[gi*3+0] = win_reg[gi*3+1];
         assign win_next[gi*3+1] = win_reg[gi*3+2];
         assign win_next[gi*3+2] = col_in[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (accept) win_reg <= win_next;
   end

   // The kernel sees the window including the column being accepted now.
   sobel_kernel #(
      .THRESH_EN (THRESH_EN),
      .THRESH    (THRESH)
   ) u_kernel (
      .win (win_next),
      .mag (mag)
   );

   assign emit = accept && (col_cur >= COL_TWO) && (row_cur >= ROW_TWO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_pixel <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (emit) begin
         out_valid <= 1'b1;
         out_pixel <= mag;
         out_sof   <= (col_cur == COL_TWO) && (row_cur == ROW_TWO);
         out_eol   <= (col_cur == COL_LAST);
         out_eof   <= (col_cur == COL_LAST) && (row_cur == ROW_LAST);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Randomized bench for sobel_edge_stream: three instances (plain, thresh 30,
// thresh 41) share one stream and are checked against a frame-image model.
module tb_sobel_edge_stream;

   localparam int W = 5;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_pixel = '0;
   logic       in_sof = 1'b0;
   logic       out_ready = 1'b1;

   logic       in_ready_w [3];
   logic       o_valid [3];
   logic [7:0] o_pix [3];
   logic       o_sof [3];
   logic       o_eol [3];
   logic       o_eof [3];

   always #5 clk = ~clk;

   sobel_edge_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH_EN(1'b0), .THRESH(128)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(o_valid[0]), .out_ready(out_ready),
      .out_pixel(o_pix[0]), .out_sof(o_sof[0]), .out_eol(o_eol[0]), .out_eof(o_eof[0]));

   sobel_edge_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH_EN(1'b1), .THRESH(30)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(o_valid[1]), .out_ready(out_ready),
      .out_pixel(o_pix[1]), .out_sof(o_sof[1]), .out_eol(o_eol[1]), .out_eof(o_eof[1]));

   sobel_edge_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH_EN(1'b1), .THRESH(41)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(o_valid[2]), .out_ready(out_ready),
      .out_pixel(o_pix[2]), .out_sof(o_sof[2]), .out_eol(o_eol[2]), .out_eof(o_eof[2]));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int img [H][W];
   int pos_col = 0;
   int pos_row = 0;
   logic [26:0] exp_q [$];   // {mag_plain, mag_t30, mag_t41, sof, eol, eof}

   function automatic int ref_mag(int r, int c, int th_en, int th);
      int gx, gy, m;
      gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
         - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
      gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
         - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m > 255) m = 255;
      if (th_en != 0) m = (m >= th) ? 255 : 0;
      return m;
   endfunction

   task automatic model_accept(input logic [7:0] p, input logic sof);
      int cr, cc;
      if (sof) begin
         pos_col = 0;
         pos_row = 0;
      end
      img[pos_row][pos_col] = int'(p);
      if (pos_col >= 2 && pos_row >= 2) begin
         cr = pos_row - 1;
         cc = pos_col - 1;
         exp_q.push_back({8'(ref_mag(cr, cc, 0, 0)), 8'(ref_mag(cr, cc, 1, 30)),
                          8'(ref_mag(cr, cc, 1, 41)),
                          1'(cr == 1 && cc == 1), 1'(cc == W-2), 1'(cc == W-2 && cr == H-2)});
      end
      pos_col++;
      if (pos_col == W) begin
         pos_col = 0;
         pos_row = (pos_row == H-1) ? 0 : pos_row + 1;
      end
   endtask

   // ---------------- out_ready driver ----------------
   int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1:       out_ready = ($urandom_range(0, 3) != 0);
         2:       out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   end

   // ---------------- output monitor ----------------
   int         out_count = 0;
   int         stall_cycles = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] held_pix;
   logic [2:0] held_flags;

   always @(negedge clk) begin
      logic [26:0] e;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         check("in_ready", in_ready_w[0], !o_valid[0] || out_ready);
         check("valid_agree", {o_valid[1], o_valid[2]}, {o_valid[0], o_valid[0]});
         if (o_valid[0] && !out_ready) stall_cycles++;
         if (stall_prev && o_valid[0]) begin
            check("hold_pix", o_pix[0], held_pix);
            check("hold_flags", {o_sof[0], o_eol[0], o_eof[0]}, held_flags);
         end
         if (o_valid[0] && out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("pix_plain", o_pix[0], e[26:19]);
               check("pix_t30", o_pix[1], e[18:11]);
               check("pix_t41", o_pix[2], e[10:3]);
               check("flags", {o_sof[0], o_eol[0], o_eof[0]}, e[2:0]);
               check("flags_t", {o_sof[1], o_eol[1], o_eof[2]}, e[2:0]);
               $display("out #%0d pix=%02h/%02h/%02h sof=%0b eol=%0b eof=%0b", out_count,
                        o_pix[0], o_pix[1], o_pix[2], o_sof[0], o_eol[0], o_eof[0]);
            end
         end
         stall_prev = o_valid[0] && !out_ready;
         held_pix   = o_pix[0];
         held_flags = {o_sof[0], o_eol[0], o_eof[0]};
      end
   end

   // ---------------- stimulus tasks ----------------
   int gaps_en = 0;

   task automatic send_px(input logic [7:0] p, input logic sof);
      int  tries;
      bit  done;
      tries = 0;
      done  = 1'b0;
      in_valid = 1'b1;
      in_pixel = p;
      in_sof   = sof;
      while (!done) begin
         @(negedge clk);
         if (in_ready_w[0]) begin
            done = 1'b1;
            model_accept(p, sof);
         end else if (++tries > 200) begin
            check("accept_timeout", 0, 1);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (gaps_en != 0 && $urandom_range(0, 3) == 0) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] pattern(int kind, int c);
      case (kind)
         0:       return 8'h80;
         1:       return (c < 2) ? 8'd0 : 8'd10;
         2:       return (c < 2) ? 8'd0 : 8'd255;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic send_frame(input int kind, input logic use_sof);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            send_px(pattern(kind, c), use_sof && r == 0 && c == 0);
   endtask

   task automatic drain_and_count(input string tag, input int expected);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || o_valid[0]) && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("drain_timeout", (t >= 300) ? 1 : 0, 0);
      check(tag, out_count, expected);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
      in_sof = 1'b0;
      @(negedge clk);
      check("rst_valid", o_valid[0], 0);
      check("rst_pix", o_pix[0], 0);
      check("rst_flags", {o_sof[0], o_eol[0], o_eof[0]}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      pos_col = 0;
      pos_row = 0;
      @(negedge clk);
      check("rst_in_ready", in_ready_w[0], 1);
      @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      repeat (2) @(posedge clk);
      do_reset();

      for (int k = 0; k < 3; k++) begin
         out_count = 0;
         send_frame(k, 1'b1);
         drain_and_count("frame_count", 6);
      end

      // Downstream stall right after the first output.
      out_count = 0;
      stall_cycles = 0;
      fork
         send_frame(0, 1'b1);
         begin
            int t;
            t = 0;
            while (!o_valid[0] && t < 200) begin
               @(negedge clk);
               t++;
            end
            check("stall_wait", (t >= 200) ? 1 : 0, 0);
            ready_mode = 2;
            repeat (5) @(negedge clk);
            ready_mode = 0;
         end
      join
      drain_and_count("stall_count", 6);
      check("stall_seen", (stall_cycles >= 4) ? 1 : 0, 1);

      // Random pixels, random backpressure and input gaps.
      ready_mode = 1;
      gaps_en = 1;
      for (int k = 0; k < 4; k++) begin
         out_count = 0;
         send_frame(3, 1'b0);
         drain_and_count("rand_count", 6);
      end
      ready_mode = 0;
      gaps_en = 0;

      // Reset mid-frame after 7 pixels, then a frame without in_sof.
      for (int i = 0; i < 7; i++) send_px(8'($urandom_range(0, 255)), i == 0);
      do_reset();
      out_count = 0;
      send_frame(3, 1'b0);
      drain_and_count("post_rst_count", 6);

      // in_sof on the 9th pixel restarts the frame.
      out_count = 0;
      for (int i = 0; i < 8; i++) send_px(8'($urandom_range(0, 255)), i == 0);
      for (int i = 0; i < W*H; i++) send_px(8'($urandom_range(0, 255)), i == 0);
      drain_and_count("resync_count", 6);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Streaming 3x3 Sobel edge detector that sits directly downstream of the grayscale stage.
- Consumes one 8-bit gray pixel per accepted beat. Use the grayscale r_out; all three channels are equal.
- Emits |Gx|+|Gy| gradient magnitude for interior pixels only, with frame and line markers.
- Two line buffers give a single-pass, raster-order, valid/ready pipeline feeding the hex-dump/writeback stage.

Parameters:
- IMG_WIDTH, 640, pixels per line (≥3).
- IMG_HEIGHT, 480, lines per frame (≥3).
- THRESH_EN, 0, 1 = binarise output: magnitude ≥ THRESH → 8'hFF, else 8'h00.
- THRESH, 128, 8-bit threshold used when THRESH_EN=1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_pixel  input  8  gray pixel, raster order.
- in_sof  input  1  pixel on this beat is (col 0, row 0); forces counter resync.
- out_valid  output  1  out_pixel valid.
- out_ready  input  1  downstream accepts.
- out_pixel  output  8  edge magnitude (saturated or thresholded).
- out_sof  output  1  output is first interior pixel (1,1).
- out_eol  output  1  output is last interior pixel of its line (col IMG_WIDTH-2).
- out_eof  output  1  output is last interior pixel of frame (IMG_WIDTH-2, IMG_HEIGHT-2).

Behaviour:
- Reset (async, active-high):
  - col=0, row=0.
  - out_valid=0; out_pixel, out_sof, out_eol, out_eof = 0.
  - in_ready=1 once rst deasserts.
  - Line-buffer contents are not cleared; they are gated by row<2.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
  - Output beat completes on out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Accept at (col,row):
  - Read top=lb1[col], mid=lb0[col], bot=in_pixel.
  - Write lb1[col]<=lb0[col] and lb0[col]<=in_pixel.
  - Shift the 3x3 window left by one column.
- Counter advance:
  - col increments; at IMG_WIDTH-1, col→0 and row increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0, ready for the next frame.
- Resync: accepted beat with in_sof=1 is treated as (0,0) regardless of counters; the window's row/col history is discarded.
- Output generation:
  - Triggered by an accepted beat with col≥2 and row≥2 (window centre = (col-1,row-1)).
  - Registers out_valid=1 and the result on the next edge, giving 1-cycle latency from the enabling input beat.
  - Otherwise out_valid clears when the current beat is taken.
  - Accept with simultaneous output drain: new result replaces the old in the same cycle, with no bubble.
- Arithmetic (window w[r][c], r,c ∈ 0..2, r=0 top):
  - Gx = (w02+2w12+w22) − (w00+2w10+w20), signed 11-bit, range ±1020.
  - Gy = (w20+2w21+w22) − (w00+2w01+w02), signed 11-bit.
  - mag = |Gx|+|Gy|, 11-bit unsigned (max 2040), saturated to 255.
  - If THRESH_EN=1, apply the threshold to the saturated value.
- Marker flags: out_sof/out_eol/out_eof are derived from the centre coordinates and registered with out_pixel.
- Output count: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) outputs per frame. Border pixels are never emitted.
- Reset mid-frame: pending output is dropped and the partial frame is discarded; the next accepted pixel is (0,0).

Decomposition:
- Package sobel_pkg holds:
  - pixel_t (8-bit) and grad_t (signed 11-bit) typedefs.
  - Kernel weight constants.
  - A sat8 function (11-bit unsigned → 8-bit saturate).
- Sub-module sobel_kernel: purely combinational, 9 pixels in, 8-bit magnitude out, THRESH_EN/THRESH params. Instantiated once.
- Line buffers stay inline as two IMG_WIDTH×8 arrays.

Test Plan:
- W=5,H=4, all pixels 0x80, out_ready=1 → 6 outputs all 0x00; out_sof on #1; out_eol on #3 and #6; out_eof on #6 only.
- W=5,H=4, every row {0,0,10,10,10} → each output row 40,40,0 (0x28,0x28,0x00).
- W=5,H=4, every row {0,0,255,255,255} → each output row 255,255,0 (saturation from 1020).
- Same as previous but THRESH_EN=1, THRESH=30 → 0xFF,0xFF,0x00; with stimulus {0,0,10,...} and THRESH=41 → all 0x00.
- out_ready held 0 for 5 cycles after first output, in_valid=1 continuously → in_ready=0 during the stall; out_pixel/flags stable; final stream identical to the first scenario (no loss/duplicate).
- Reset pulse after 7 accepted pixels, then a full frame → no output before row 2; exactly 6 outputs. Separately, in_sof asserted at pixel 9 of a frame → counters restart, the following 20 pixels yield 6 outputs.
